// File: rtl/fiestel_structure_top_if.sv
// Block bus of the 5-round Feistel cipher: plaintext, round keys, S-box rows,
// table-valid qualifier and the registered ciphertext.
interface fiestel_structure_top_if;
  logic [255:0] plane_text_in;
  logic [255:0] cypher_text_out;
  logic [127:0] key_for_round_0;
  logic [127:0] key_for_round_1;
  logic [127:0] key_for_round_2;
  logic [127:0] key_for_round_3;
  logic [127:0] key_for_round_4;
  logic [127:0] substitution_box_row0;
  logic [127:0] substitution_box_row1;
  logic [127:0] substitution_box_row2;
  logic [127:0] substitution_box_row3;
  logic [127:0] substitution_box_row4;
  logic [127:0] substitution_box_row5;
  logic [127:0] substitution_box_row6;
  logic [127:0] substitution_box_row7;
  logic [127:0] substitution_box_row8;
  logic [127:0] substitution_box_row9;
  logic [127:0] substitution_box_row10;
  logic [127:0] substitution_box_row11;
  logic [127:0] substitution_box_row12;
  logic [127:0] substitution_box_row13;
  logic [127:0] substitution_box_row14;
  logic [127:0] substitution_box_row15;
  logic         substitution_table_valid;

  modport master (
    output plane_text_in,
    output key_for_round_0, key_for_round_1, key_for_round_2, key_for_round_3, key_for_round_4,
    output substitution_box_row0, substitution_box_row1, substitution_box_row2, substitution_box_row3,
    output substitution_box_row4, substitution_box_row5, substitution_box_row6, substitution_box_row7,
    output substitution_box_row8, substitution_box_row9, substitution_box_row10, substitution_box_row11,
    output substitution_box_row12, substitution_box_row13, substitution_box_row14, substitution_box_row15,
    output substitution_table_valid,
    input  cypher_text_out
  );

  modport slave (
    input  plane_text_in,
    input  key_for_round_0, key_for_round_1, key_for_round_2, key_for_round_3, key_for_round_4,
    input  substitution_box_row0, substitution_box_row1, substitution_box_row2, substitution_box_row3,
    input  substitution_box_row4, substitution_box_row5, substitution_box_row6, substitution_box_row7,
    input  substitution_box_row8, substitution_box_row9, substitution_box_row10, substitution_box_row11,
    input  substitution_box_row12, substitution_box_row13, substitution_box_row14, substitution_box_row15,
    input  substitution_table_valid,
    output cypher_text_out
  );
endinterface

// File: rtl/fiestel_structure_top.sv
// Five-round 256-bit Feistel cipher, fully combinational rounds feeding one
// output register; swapped final halves let the same block decrypt.
module fiestel_round (
  input  logic [255:0][7:0] sbox,
  input  logic [127:0]      l_in,
  input  logic [127:0]      r_in,
  input  logic [127:0]      key,
  output logic [127:0]      l_out,
  output logic [127:0]      r_out
);
  logic [15:0][7:0] t;
  logic [15:0][7:0] s;

  assign t = r_in ^ key;

  for (genvar b = 0; b < 16; b++) begin : g_byte
    assign s[b] = sbox[t[b]];
  end

  assign l_out = r_in;
  // byte rotate left: old MSB byte wraps to the LSB position
  assign r_out = l_in ^ {s[14:0], s[15]};
endmodule

module fiestel_structure_top (
  input  logic                    clk,
  input  logic                    rst,
  fiestel_structure_top_if.slave  bus
);
  localparam int NUM_ROUNDS = 5;

  logic [15:0][127:0]           rows;
  logic [255:0][7:0]            sbox;
  logic [NUM_ROUNDS-1:0][127:0] keys;
  logic [NUM_ROUNDS:0][127:0]   l;
  logic [NUM_ROUNDS:0][127:0]   r;
  logic [255:0]                 ct_q;

  assign rows = {bus.substitution_box_row15, bus.substitution_box_row14,
                 bus.substitution_box_row13, bus.substitution_box_row12,
                 bus.substitution_box_row11, bus.substitution_box_row10,
                 bus.substitution_box_row9,  bus.substitution_box_row8,
                 bus.substitution_box_row7,  bus.substitution_box_row6,
                 bus.substitution_box_row5,  bus.substitution_box_row4,
                 bus.substitution_box_row3,  bus.substitution_box_row2,
                 bus.substitution_box_row1,  bus.substitution_box_row0};

  assign keys = {bus.key_for_round_4, bus.key_for_round_3, bus.key_for_round_2,
                 bus.key_for_round_1, bus.key_for_round_0};

  // entry v lives in row v[7:4]; column 0 is the row's MSB byte
  for (genvar rw = 0; rw < 16; rw++) begin : g_row
    for (genvar c = 0; c < 16; c++) begin : g_col
      assign sbox[16*rw + c] = rows[rw][127-8*c -: 8];
    end
  end

  assign l[0] = bus.plane_text_in[255:128];
  assign r[0] = bus.plane_text_in[127:0];

  for (genvar i = 0; i < NUM_ROUNDS; i++) begin : g_rnd
    fiestel_round u_rnd (
      .sbox  (sbox),
      .l_in  (l[i]),
      .r_in  (r[i]),
      .key   (keys[i]),
      .l_out (l[i+1]),
      .r_out (r[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)                               ct_q <= '0;
    else if (bus.substitution_table_valid) ct_q <= {r[NUM_ROUNDS], l[NUM_ROUNDS]};
  end

  assign bus.cypher_text_out = ct_q;
endmodule

// File: tb/tb_fiestel_structure_top.sv
// Directed bench for the Feistel cipher: hand-computed all-zero vector, reset,
// valid gating, round trip through the decrypt direction, streaming, rotation.
module tb_fiestel_structure_top;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fiestel_structure_top_if bus ();
  fiestel_structure_top dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  logic [127:0] aes_rows [16];
  logic [127:0] k [5];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] v);
    return aes_rows[v[7:4]][8*(15-int'(v[3:0])) +: 8];
  endfunction

  // byte-array reference; byte index 0 is the most significant byte
  function automatic logic [255:0] model(input logic [255:0] pt);
    logic [7:0] lb [16];
    logic [7:0] rb [16];
    logic [7:0] s  [16];
    logic [7:0] nb [16];
    logic [255:0] o;
    for (int j = 0; j < 16; j++) begin
      lb[j] = pt[255-8*j -: 8];
      rb[j] = pt[127-8*j -: 8];
    end
    for (int rn = 0; rn < 5; rn++) begin
      for (int j = 0; j < 16; j++) s[j] = sb(rb[j] ^ k[rn][127-8*j -: 8]);
      for (int j = 0; j < 16; j++) nb[j] = lb[j] ^ s[(j+1) % 16];
      for (int j = 0; j < 16; j++) begin
        lb[j] = rb[j];
        rb[j] = nb[j];
      end
    end
    o = '0;
    for (int j = 0; j < 16; j++) begin
      o[255-8*j -: 8] = rb[j];
      o[127-8*j -: 8] = lb[j];
    end
    return o;
  endfunction

  task automatic drive_keys();
    bus.key_for_round_0 = k[0];
    bus.key_for_round_1 = k[1];
    bus.key_for_round_2 = k[2];
    bus.key_for_round_3 = k[3];
    bus.key_for_round_4 = k[4];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [255:0] ZERO_CT = {{16{8'h0e}}, {16{8'hab}}};
  localparam logic [255:0] RT_PT =
    256'h8b0fc5ee6e08e497c2ef4b9108428a1fbc01533bc8c895074590da3fb58e07a0;

  logic [255:0] exp_v, saved, prev_pt, vec;
  logic [127:0] ktmp;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    aes_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    aes_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    aes_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    aes_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    aes_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    aes_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    aes_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    aes_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    aes_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    aes_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    aes_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    aes_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    aes_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    aes_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    aes_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    aes_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    bus.substitution_box_row0  = aes_rows[0];
    bus.substitution_box_row1  = aes_rows[1];
    bus.substitution_box_row2  = aes_rows[2];
    bus.substitution_box_row3  = aes_rows[3];
    bus.substitution_box_row4  = aes_rows[4];
    bus.substitution_box_row5  = aes_rows[5];
    bus.substitution_box_row6  = aes_rows[6];
    bus.substitution_box_row7  = aes_rows[7];
    bus.substitution_box_row8  = aes_rows[8];
    bus.substitution_box_row9  = aes_rows[9];
    bus.substitution_box_row10 = aes_rows[10];
    bus.substitution_box_row11 = aes_rows[11];
    bus.substitution_box_row12 = aes_rows[12];
    bus.substitution_box_row13 = aes_rows[13];
    bus.substitution_box_row14 = aes_rows[14];
    bus.substitution_box_row15 = aes_rows[15];

    // reset with nonzero stimulus; second edge also has valid low
    rst = 1'b1;
    bus.substitution_table_valid = 1'b1;
    bus.plane_text_in = RT_PT;
    for (int i = 0; i < 5; i++) k[i] = {4{32'hc0ffee00 + 32'(i)}};
    drive_keys();
    tick();
    chk("rst_edge1", bus.cypher_text_out, '0);
    bus.substitution_table_valid = 1'b0;
    tick();
    chk("rst_edge2", bus.cypher_text_out, '0);

    // all-zero vector, first edge after reset release
    bus.plane_text_in = '0;
    for (int i = 0; i < 5; i++) k[i] = '0;
    drive_keys();
    bus.substitution_table_valid = 1'b1;
    rst = 1'b0;
    tick();
    chk("all_zero", bus.cypher_text_out, ZERO_CT);

    // valid gating
    k[0] = 128'h00112233445566778899aabbccddeeff;
    k[1] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    k[2] = 128'hdeadbeefcafebabe0123456789abcdef;
    k[3] = 128'h13579bdf2468ace0fdb97531eca86420;
    k[4] = 128'ha5a5a5a55a5a5a5aff00ff0000ff00ff;
    drive_keys();
    bus.plane_text_in = {8{32'h12345678}};
    tick();
    saved = model({8{32'h12345678}});
    chk("gate_load", bus.cypher_text_out, saved);
    bus.substitution_table_valid = 1'b0;
    bus.plane_text_in = {8{32'hfedcba98}};
    tick();
    tick();
    chk("gate_hold", bus.cypher_text_out, saved);
    bus.substitution_table_valid = 1'b1;
    tick();
    chk("gate_resume", bus.cypher_text_out, model({8{32'hfedcba98}}));

    // round trip: encrypt, then feed ciphertext back with reversed keys
    bus.plane_text_in = RT_PT;
    tick();
    saved = bus.cypher_text_out;
    chk("rt_enc_model", saved, model(RT_PT));
    for (int i = 0; i < 2; i++) begin
      ktmp = k[i];
      k[i] = k[4-i];
      k[4-i] = ktmp;
    end
    drive_keys();
    bus.plane_text_in = saved;
    tick();
    chk("rt_decrypt", bus.cypher_text_out, RT_PT);

    // back-to-back: a new block every cycle
    prev_pt = '0;
    for (int i = 0; i < 8; i++) begin
      vec = {8{32'h9e3779b9 + 32'(i) * 32'h7f4a7c15}} ^ (256'hbeef << (16*i));
      bus.plane_text_in = vec;
      if (i > 0) chk($sformatf("b2b_%0d", i-1), bus.cypher_text_out, model(prev_pt));
      prev_pt = vec;
      tick();
    end
    chk("b2b_7", bus.cypher_text_out, model(prev_pt));

    // reset mid-stream overrides the pending update
    bus.plane_text_in = {4{64'h0123456789abcdef}};
    rst = 1'b1;
    tick();
    chk("midrst_zero", bus.cypher_text_out, '0);
    rst = 1'b0;
    tick();
    chk("midrst_first", bus.cypher_text_out, model({4{64'h0123456789abcdef}}));

    // rotation direction and column order
    for (int i = 0; i < 5; i++) k[i] = '0;
    k[0] = 128'h01;
    drive_keys();
    bus.plane_text_in = '0;
    tick();
    chk("rotation", bus.cypher_text_out, model('0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fiestel_structure_top.md
FIESTEL_STRUCTURE_TOP -- requirements
Module: fiestel_structure_top

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 plane_text_in  in  256  plaintext block; L0=[255:128], R0=[127:0].
REQ-005 cypher_text_out  out  256  registered ciphertext.
REQ-006 key_for_round_0..key_for_round_4  in  128 each  round keys; round i uses key_for_round_i.
REQ-007 substitution_box_row0..substitution_box_row15  in  128 each  8-bit S-box, 256 entries.
REQ-008 substitution_table_valid  in  1  S-box and keys usable; enables output register update.

Function
REQ-009 SHALL look up S-box entry sbox[v] as follows:
- row = v[7:4] selects substitution_box_row<row>.
- col = v[3:0] selects the byte at bits [127-8*col : 120-8*col]; column 0 is the MSB byte.
REQ-010 SHALL compute the round function F(R,K) in three steps:
- T = R ^ K.
- S = T with every byte b replaced by sbox[b].
- F = S rotated left by 8 bits across all 128 bits.
REQ-011 SHALL apply the round update for i = 0..4:
- L(i+1) = R(i).
- R(i+1) = L(i) ^ F(R(i), key_for_round_i).
REQ-012 SHALL form the result as {R5, L5}, with the final halves swapped.
- This lets the decryptor use the same structure with keys in order 4..0.
REQ-013 SHALL compute all five rounds combinationally from the current inputs.
REQ-014 SHALL register the result into cypher_text_out on the rising edge.
- Latency: exactly 1 clock from input to output.
- Throughput: one block per cycle.
REQ-015 SHALL update cypher_text_out only in cycles where rst=0 and substitution_table_valid=1.
- Otherwise the register holds its value.
REQ-016 SHALL track plaintext or key changes on the next enabled edge; no handshake and no internal state beyond the output register.
REQ-017 SHALL use only XOR, table lookup and fixed rotation; no arithmetic carries, all widths exact (128-bit halves, 256-bit block).
REQ-018 SHALL output X or undefined values on no path; unknown-free inputs yield unknown-free outputs.

Reset
REQ-019 SHALL load cypher_text_out with 256'h0 on any rising edge with rst=1.
- Applies regardless of substitution_table_valid.
REQ-020 SHALL let rst asserted mid-stream override the pending update; the first result appears one edge after rst deasserts.

Verification
REQ-021 All-zero case: plaintext = 0, all keys = 0, AES S-box loaded, valid=1, rst released.
- Stimulus: one edge.
- Required: cypher_text_out = {16{8'h0e}} in [255:128], {16{8'hab}} in [127:0].
REQ-022 Reset: rst=1 for 2 edges with nonzero stimulus.
- Required: cypher_text_out = 0.
- After rst falls, output matches the REQ-021 value on the first edge.
REQ-023 Valid gating: after a result is loaded, set substitution_table_valid=0 and change plane_text_in.
- Required: output unchanged.
- Set valid=1 again: new result appears on the next edge.
REQ-024 Round trip: plaintext 256'h8b0fc5ee6e08e497c2ef4b9108428a1fbc01533bc8c895074590da3fb58e07a0, AES S-box, arbitrary keys.
- Check: the software reference model of REQ-009..REQ-012 matches.
- Check: the decryptor with reversed keys reproduces the plaintext.
REQ-025 Back-to-back: apply a new plaintext every cycle for 8 cycles.
- Required: each output equals the model of the plaintext one cycle earlier.
REQ-026 Rotation check: plaintext = 0, key_for_round_0 = 128'h01, other keys 0.
- Required: output equals the model, confirming the byte rotation direction and S-box column order (MSB byte = column 0).
